// File: rtl/mult_pkg.sv
// Shared types and defaults for the shared-multiplier arbiter.
package mult_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} arb_state_t;
  typedef logic ch_id_t;
  localparam int TIMEOUT_DEFAULT = 64;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: grants the lone requester, or the pointer's channel on contention.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  input  logic       i_en,
  output logic [1:0] o_gnt,
  output logic       o_ptr_next
);
  always_comb begin
    o_gnt      = 2'b00;
    o_ptr_next = i_ptr;
    if (i_en) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = i_ptr ? 2'b10 : 2'b01;
        default: o_gnt = 2'b00;
      endcase
      // After any grant the other channel gets priority next time.
      if (o_gnt != 2'b00) o_ptr_next = ~o_gnt[1];
    end
  end
endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one sequential multiplier between two channels: round-robin grant,
// launch, bounded wait for END, then per-channel valid/ready result return.
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int tamano      = 8,
  parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic [tamano-1:0]     A0,
  input  logic [tamano-1:0]     A1,
  input  logic [tamano-1:0]     B0,
  input  logic [tamano-1:0]     B1,
  output logic                  GNT0,
  output logic                  GNT1,
  output logic                  VALID0,
  output logic                  VALID1,
  output logic [2*tamano-1:0]   S0,
  output logic [2*tamano-1:0]   S1,
  input  logic                  READY0,
  input  logic                  READY1,
  output logic                  ERR,
  output logic                  MULT_START,
  output logic [tamano-1:0]     MULT_A,
  output logic [tamano-1:0]     MULT_B,
  input  logic [2*tamano-1:0]   MULT_S,
  input  logic                  MULT_END,
  output logic                  BUSY
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYC);

  arb_state_t          r_state, w_state_next;
  ch_id_t              r_owner;
  logic                r_ptr, w_ptr_next, w_arb_en;
  logic [1:0]          w_arb_gnt;
  logic [CW-1:0]       r_cnt;
  logic [tamano-1:0]   r_a, r_b;
  logic [2*tamano-1:0] r_s0, r_s1;
  logic                r_err;
  logic                w_timeout, w_ready_own;

  // Gate with RESET so no grant is shown for a cycle that will be discarded.
  assign w_arb_en    = (r_state == IDLE) && !RESET;
  assign w_timeout   = (r_cnt >= CNT_LAST);
  assign w_ready_own = r_owner ? READY1 : READY0;

  rr_arb2 u_arb (
    .i_req      ({REQ1, REQ0}),
    .i_ptr      (r_ptr),
    .i_en       (w_arb_en),
    .o_gnt      (w_arb_gnt),
    .o_ptr_next (w_ptr_next)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    MULT_START   = 1'b0;
    VALID0       = 1'b0;
    VALID1       = 1'b0;
    BUSY         = (r_state != IDLE);
    case (r_state)
      IDLE:   if (w_arb_gnt != 2'b00) w_state_next = LAUNCH;
      LAUNCH: begin
        MULT_START   = 1'b1;
        w_state_next = WAIT;
      end
      WAIT:   if (MULT_END || w_timeout) w_state_next = DONE;
      DONE: begin
        VALID0 = !r_owner;
        VALID1 = r_owner;
        if (w_ready_own) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_owner <= 1'b0;
      r_ptr   <= 1'b0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_s0    <= '0;
      r_s1    <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_arb_gnt != 2'b00) begin
          r_owner <= w_arb_gnt[1];
          r_ptr   <= w_ptr_next;
          r_a     <= w_arb_gnt[1] ? A1 : A0;
          r_b     <= w_arb_gnt[1] ? B1 : B0;
        end
        LAUNCH: r_cnt <= '0;
        WAIT: begin
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
          if (MULT_END) begin
            if (r_owner) r_s1 <= MULT_S;
            else         r_s0 <= MULT_S;
          end else if (w_timeout) begin
            if (r_owner) r_s1 <= '0;
            else         r_s0 <= '0;
            r_err <= 1'b1;
          end
        end
        DONE: if (w_ready_own) r_err <= 1'b0;
        default: ;
      endcase
    end
  end

  assign GNT0   = w_arb_gnt[0];
  assign GNT1   = w_arb_gnt[1];
  assign S0     = r_s0;
  assign S1     = r_s1;
  assign ERR    = r_err;
  assign MULT_A = r_a;
  assign MULT_B = r_b;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural multiplier stub.
module tb_mult_share_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 0, req1 = 0, rdy0 = 0, rdy1 = 0;
  logic [7:0]  a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic        gnt0, gnt1, valid0, valid1, err, mult_start, busy;
  logic [15:0] s0, s1;
  logic [7:0]  mult_a, mult_b;
  logic [15:0] mult_s = 0;
  logic        mult_end = 0;

  int total = 0;
  int bad   = 0;
  bit stall = 0;
  int lat   = 3;
  bit          m_act = 0;
  int          m_cnt = 0;
  logic [15:0] m_p = 0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.tamano(8), .TIMEOUT_CYC(64)) dut (
    .CLOCK(clk), .RESET(rst), .REQ0(req0), .REQ1(req1),
    .A0(a0), .A1(a1), .B0(b0), .B1(b1),
    .GNT0(gnt0), .GNT1(gnt1), .VALID0(valid0), .VALID1(valid1),
    .S0(s0), .S1(s1), .READY0(rdy0), .READY1(rdy1), .ERR(err),
    .MULT_START(mult_start), .MULT_A(mult_a), .MULT_B(mult_b),
    .MULT_S(mult_s), .MULT_END(mult_end), .BUSY(busy)
  );

  // Multiplier stub: fixed latency after START, or never finishes when stalled.
  always @(posedge clk) begin
    if (rst) begin
      m_act    <= 0;
      m_cnt    <= 0;
      mult_end <= 0;
      mult_s   <= 0;
    end else begin
      mult_end <= 1'b0;
      if (mult_start && !stall) begin
        m_act <= 1;
        m_cnt <= lat;
        m_p   <= mult_a * mult_b;
      end else if (m_act) begin
        if (m_cnt <= 1) begin
          mult_end <= 1'b1;
          mult_s   <= m_p;
          m_act    <= 0;
        end else m_cnt <= m_cnt - 1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    req0 = 0; req1 = 0; rdy0 = 0; rdy1 = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic wait_gnt(input int ch, output bit ok, output int cyc);
    ok = 0; cyc = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if ((ch == 0) ? gnt0 : gnt1) begin ok = 1; cyc = i; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int ch, output bit ok, output int cyc);
    ok = 0; cyc = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if ((ch == 0) ? valid0 : valid1) begin ok = 1; cyc = i; break; end
      @(negedge clk);
    end
  endtask

  task automatic consume(input int ch);
    if (ch == 0) rdy0 = 1; else rdy1 = 1;
    @(negedge clk);
    rdy0 = 0; rdy1 = 0;
  endtask

  // Drives one full operation; lat_o counts cycles from GNT to VALID.
  task automatic run_op(input int ch, input logic [7:0] a, input logic [7:0] b,
                        output bit ok, output logic [15:0] s, output logic e, output int lat_o);
    bit g_ok, v_ok;
    int c;
    ok = 0; s = 'x; e = 'x; lat_o = -1;
    if (ch == 0) begin a0 = a; b0 = b; req0 = 1; end
    else         begin a1 = a; b1 = b; req1 = 1; end
    wait_gnt(ch, g_ok, c);
    @(negedge clk);
    req0 = 0; req1 = 0;
    if (!g_ok) return;
    wait_valid(ch, v_ok, c);
    lat_o = c + 1;
    s = (ch == 0) ? s0 : s1;
    e = err;
    consume(ch);
    ok = v_ok;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if ({gnt0, gnt1, valid0, valid1, err, mult_start, busy} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000000", {gnt0, gnt1, valid0, valid1, err, mult_start, busy});
    end
    total++; if ({s0, s1, mult_a, mult_b} !== 48'h0) begin
      bad++; $display("FAIL reset_data: got s0=%h s1=%h a=%h b=%h want all 0", s0, s1, mult_a, mult_b);
    end
    $display("reset: ctrl=%b", {gnt0, gnt1, valid0, valid1, err, mult_start, busy});
  endtask

  task automatic test_single();
    bit ok; int c;
    @(negedge clk);
    a0 = 7; b0 = 9; req0 = 1;
    wait_gnt(0, ok, c);
    total++; if (!ok || gnt1 !== 1'b0) begin
      bad++; $display("FAIL single_gnt: got gnt0 seen=%0b gnt1=%b want 1/0", ok, gnt1);
    end
    @(negedge clk);
    req0 = 0;
    #1;
    total++; if ({mult_start, gnt0, busy} !== 3'b101 || mult_a !== 8'd7 || mult_b !== 8'd9) begin
      bad++; $display("FAIL single_launch: got start=%b gnt0=%b busy=%b a=%0d b=%0d want 1 0 1 7 9",
                      mult_start, gnt0, busy, mult_a, mult_b);
    end
    @(negedge clk);
    #1;
    total++; if (mult_start !== 1'b0) begin
      bad++; $display("FAIL single_start_pulse: got %b want 0", mult_start);
    end
    wait_valid(0, ok, c);
    total++; if (!ok || s0 !== 16'd63 || err !== 1'b0 || valid1 !== 1'b0) begin
      bad++; $display("FAIL single_result: got valid=%0b s0=%0d err=%b valid1=%b want 1 63 0 0", ok, s0, err, valid1);
    end
    repeat (3) @(negedge clk);
    #1;
    total++; if (valid0 !== 1'b1 || s0 !== 16'd63) begin
      bad++; $display("FAIL single_hold: got valid0=%b s0=%0d want 1 63", valid0, s0);
    end
    rdy1 = 1;
    @(negedge clk);
    rdy1 = 0;
    #1;
    total++; if (valid0 !== 1'b1) begin
      bad++; $display("FAIL single_foreign_ready: got valid0=%b want 1", valid0);
    end
    @(negedge clk);
    consume(0);
    #1;
    total++; if (valid0 !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL single_consume: got valid0=%b busy=%b want 0 0", valid0, busy);
    end
    $display("single: 7*9 -> s0=%0d", s0);
  endtask

  task automatic test_both();
    bit ok; int c;
    do_reset();
    a0 = 3; b0 = 5; a1 = 12; b1 = 11; req0 = 1; req1 = 1;
    wait_gnt(0, ok, c);
    total++; if (!ok || gnt1 !== 1'b0) begin
      bad++; $display("FAIL both_first: got gnt0 seen=%0b gnt1=%b want 1 0", ok, gnt1);
    end
    @(negedge clk);
    req0 = 0;
    wait_valid(0, ok, c);
    total++; if (!ok || s0 !== 16'd15 || valid1 !== 1'b0) begin
      bad++; $display("FAIL both_ch0: got valid=%0b s0=%0d valid1=%b want 1 15 0", ok, s0, valid1);
    end
    consume(0);
    wait_gnt(1, ok, c);
    total++; if (!ok || c !== 0) begin
      bad++; $display("FAIL both_second_gnt: got seen=%0b after %0d cycles want 1 after 0", ok, c);
    end
    @(negedge clk);
    req1 = 0;
    wait_valid(1, ok, c);
    total++; if (!ok || s1 !== 16'd132 || valid0 !== 1'b0) begin
      bad++; $display("FAIL both_ch1: got valid=%0b s1=%0d valid0=%b want 1 132 0", ok, s1, valid0);
    end
    consume(1);
    $display("both: s0=%0d s1=%0d", s0, s1);
  endtask

  task automatic test_alternate();
    bit ok, seen; int c, g;
    do_reset();
    a0 = 2; b0 = 2; a1 = 3; b1 = 3; req0 = 1; req1 = 1;
    for (int k = 0; k < 6; k++) begin
      seen = 0; g = -1;
      for (int i = 0; i < 100; i++) begin
        #1;
        if (gnt0 || gnt1) begin seen = 1; g = gnt1 ? 1 : 0; break; end
        @(negedge clk);
      end
      total++; if (!seen || (gnt0 && gnt1) || g !== (k % 2)) begin
        bad++; $display("FAIL alt_order op%0d: got ch=%0d want ch=%0d", k, g, k % 2);
      end
      if (!seen) break;
      @(negedge clk);
      #1;
      total++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
        bad++; $display("FAIL alt_no_b2b op%0d: got gnt=%b%b want 00", k, gnt1, gnt0);
      end
      wait_valid(g, ok, c);
      consume(g);
      $display("alternate: op%0d granted ch%0d", k, g);
    end
    req0 = 0; req1 = 0;
    @(negedge clk);
  endtask

  task automatic test_extremes();
    bit ok; logic [15:0] s; logic e; int l;
    run_op(0, 8'd255, 8'd255, ok, s, e, l);
    total++; if (!ok || s !== 16'hFE01 || e !== 1'b0) begin
      bad++; $display("FAIL ext_255x255: got ok=%0b s=%h err=%b want 1 fe01 0", ok, s, e);
    end
    $display("extreme: 255*255 -> %h", s);
    run_op(1, 8'd0, 8'd200, ok, s, e, l);
    total++; if (!ok || s !== 16'd0 || e !== 1'b0) begin
      bad++; $display("FAIL ext_0x200: got ok=%0b s=%0d err=%b want 1 0 0", ok, s, e);
    end
    $display("extreme: 0*200 -> %0d", s);
    run_op(0, 8'd1, 8'd255, ok, s, e, l);
    total++; if (!ok || s !== 16'd255 || e !== 1'b0) begin
      bad++; $display("FAIL ext_1x255: got ok=%0b s=%0d err=%b want 1 255 0", ok, s, e);
    end
    $display("extreme: 1*255 -> %0d", s);
  endtask

  task automatic test_timeout();
    bit ok; logic [15:0] s; logic e; int l;
    stall = 1;
    run_op(1, 8'd5, 8'd6, ok, s, e, l);
    stall = 0;
    total++; if (!ok || e !== 1'b1 || s !== 16'd0) begin
      bad++; $display("FAIL timeout_result: got ok=%0b err=%b s1=%0d want 1 1 0", ok, e, s);
    end
    total++; if (l < 64 || l > 70) begin
      bad++; $display("FAIL timeout_latency: got %0d cycles want 64..70", l);
    end
    #1;
    total++; if (busy !== 1'b0 || err !== 1'b0 || valid1 !== 1'b0) begin
      bad++; $display("FAIL timeout_idle: got busy=%b err=%b valid1=%b want 0 0 0", busy, err, valid1);
    end
    $display("timeout: latency=%0d err=%b", l, e);
    run_op(0, 8'd2, 8'd3, ok, s, e, l);
    total++; if (!ok || s !== 16'd6 || e !== 1'b0) begin
      bad++; $display("FAIL timeout_recover: got ok=%0b s=%0d err=%b want 1 6 0", ok, s, e);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int c, vcount; logic [15:0] s; logic e; int l;
    stall = 1;
    a0 = 4; b0 = 4; req0 = 1;
    wait_gnt(0, ok, c);
    @(negedge clk);
    req0 = 0;
    repeat (3) @(negedge clk);
    stall = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    total++; if ({gnt0, gnt1, valid0, valid1, err, mult_start, busy} !== 7'b0 || mult_a !== 8'd0) begin
      bad++; $display("FAIL rst_wait: got ctrl=%b a=%0d want 0000000 0",
                      {gnt0, gnt1, valid0, valid1, err, mult_start, busy}, mult_a);
    end
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (valid0 || valid1 || err) vcount++;
    end
    total++; if (vcount !== 0) begin
      bad++; $display("FAIL rst_wait_silent: got %0d valid cycles want 0", vcount);
    end
    a0 = 9; b0 = 9; req0 = 1;
    wait_gnt(0, ok, c);
    @(negedge clk);
    req0 = 0;
    wait_valid(0, ok, c);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    total++; if ({valid0, valid1, err, busy} !== 4'b0 || s0 !== 16'd0) begin
      bad++; $display("FAIL rst_done: got valid=%b%b err=%b busy=%b s0=%0d want 0 0 0 0 0",
                      valid1, valid0, err, busy, s0);
    end
    @(negedge clk);
    run_op(1, 8'd6, 8'd7, ok, s, e, l);
    total++; if (!ok || s !== 16'd42 || e !== 1'b0) begin
      bad++; $display("FAIL rst_resume: got ok=%0b s1=%0d err=%b want 1 42 0", ok, s, e);
    end
    $display("reset_mid: resumed s1=%0d", s);
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_alternate();
    test_extremes();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
